// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side streaming adapter.
//   occ_t  : skid buffer occupancy (EMPTY / ONE / TWO)
//   STAT_W : width of the accepted-beat statistic
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int STAT_W = 32;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer between the FIFO pop side and the output stream.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   flush      : drop all buffered words (next state EMPTY)
//   push       : capture push_data this cycle
//   push_data  : word to capture
//   pop        : head word accepted downstream this cycle
//   state      : current occupancy
//   valid      : buffer holds at least one word
//   data       : oldest buffered word
module rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output occ_t              state,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  occ_t              state_nxt;
  logic [DATA_W-1:0] d0, d1;
  logic [DATA_W-1:0] d0_nxt, d1_nxt;

  // Data words are cleared on reset as well so the head reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      d0    <= '0;
      d1    <= '0;
    end else begin
      state <= state_nxt;
      d0    <= d0_nxt;
      d1    <= d1_nxt;
    end
  end

  // d0 is always the head; d1 only holds the second word in TWO.
  always_comb begin
    state_nxt = state;
    d0_nxt    = d0;
    d1_nxt    = d1;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            d0_nxt    = push_data;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: d0_nxt = push_data;
            2'b10: begin
              state_nxt = TWO;
              d1_nxt    = push_data;
            end
            2'b01: state_nxt = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          // A push in TWO only happens alongside a pop, so the words shift.
          if (pop) begin
            d0_nxt = d1;
            if (push) d1_nxt = push_data;
            else      state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign valid = (state != EMPTY);
  assign data  = d0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the read side of a FIFO (empty flag + combinational head word)
// into a valid/ready stream framed into packets of PKT_LEN beats.
// Optional statistics: define FIFO_RD_STREAM_STATS_EN to count accepted
// beats on beat_cnt (saturating); otherwise beat_cnt is tied to 0.
// Ports:
//   rclk, rrst  : read clock, synchronous active-high reset
//   fifo_rempty : FIFO empty flag
//   fifo_rdata  : FIFO head word
//   fifo_rinc   : FIFO pop strobe
//   flush       : discard buffered words, restart framing
//   m_valid, m_ready, m_data, m_last : output stream
//   beat_cnt    : accepted-beat statistic
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              fifo_rempty,
  input  logic [DSIZE-1:0]  fifo_rdata,
  output logic              fifo_rinc,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DSIZE-1:0]  m_data,
  output logic              m_last,
  output logic [STAT_W-1:0] beat_cnt
);

  localparam int                PCNT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PKT_LEN - 1);

  occ_t              state;
  logic              buf_valid;
  logic              accept;
  logic [PCNT_W-1:0] pcnt;

  // Outputs are forced quiet during reset even before the state register clears.
  assign m_valid   = buf_valid && !rrst;
  assign accept    = m_valid && m_ready;
  assign fifo_rinc = !rrst && !fifo_rempty && !flush && ((state != TWO) || accept);
  assign m_last    = m_valid && (pcnt == PCNT_LAST);

  rd_skid_buf #(
    .DATA_W (DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .flush     (flush),
    .push      (fifo_rinc),
    .push_data (fifo_rdata),
    .pop       (accept),
    .state     (state),
    .valid     (buf_valid),
    .data      (m_data)
  );

  // A beat accepted together with flush is delivered but does not advance framing.
  always_ff @(posedge rclk) begin
    if (rrst || flush) begin
      pcnt <= '0;
    end else if (accept) begin
      pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge rclk) begin
    if (rrst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= sat_inc(beat_cnt);
    end
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a simple FIFO read-side model.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        fifo_rempty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rinc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [31:0] beat_cnt;

  logic [7:0]  mem [0:63];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rclk = ~rclk;

  assign fifo_rempty = (rd_ptr == wr_ptr);
  assign fifo_rdata  = mem[rd_ptr[5:0]];

  always @(posedge rclk) if (fifo_rinc) rd_ptr <= rd_ptr + 8'd1;

  fifo_rd_stream #(
    .DSIZE   (8),
    .PKT_LEN (4)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .beat_cnt    (beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick();
    @(negedge rclk);
  endtask

  logic [7:0] exp_a [0:3];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);

    // Reset: outputs quiet even though the FIFO holds data
    tick(); #1;
    chk("rst_rinc", fifo_rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    tick();
    chk("rst_data", m_data, 0);
    chk("rst_beat", beat_cnt, 0);

    // Streaming 11,22,33,44 with m_ready high
    exp_a[0] = 8'h11; exp_a[1] = 8'h22; exp_a[2] = 8'h33; exp_a[3] = 8'h44;
    rrst = 1'b0; m_ready = 1'b1; #1;
    chk("t1_rinc0", fifo_rinc, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data, exp_a[k]);
      chk("t1_last", m_last, (k == 3) ? 1 : 0);
      #1 chk("t1_rinc", fifo_rinc, (k < 3) ? 1 : 0);
    end
    chk("t1_pops", rd_ptr, 4);
    tick();
    chk("t1_idle", m_valid, 0);

    // Back-pressure: exactly two pops, head held, then ordered drain
    exp_a[0] = 8'hA1; exp_a[1] = 8'hA2; exp_a[2] = 8'hA3; exp_a[3] = 8'hA4;
    m_ready = 1'b0;
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
    #1 chk("t2_rinc0", fifo_rinc, 1);
    tick();
    chk("t2_data1", m_data, 8'hA1);
    #1 chk("t2_rinc1", fifo_rinc, 1);
    tick();
    chk("t2_data2", m_data, 8'hA1);
    #1 chk("t2_rinc2", fifo_rinc, 0);
    tick();
    chk("t2_hold", m_data, 8'hA1);
    chk("t2_holdlast", m_last, 0);
    chk("t2_pops", rd_ptr, 6);
    m_ready = 1'b1;
    #1 chk("t2_rinc_acc", fifo_rinc, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t2_data", m_data, exp_a[k]);
      chk("t2_last", m_last, (k == 3) ? 1 : 0);
    end
    tick();
    chk("t2_idle", m_valid, 0);

    // Empty FIFO: no pops, no valid
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 chk("t3_rinc", fifo_rinc, 0);
      chk("t3_valid", m_valid, 0);
    end

    // Flush in TWO at pcnt=2, with a beat accepted in the flush cycle
    for (int k = 1; k <= 8; k++) load(8'hB0 + 8'(k));
    #1 chk("t4_rinc0", fifo_rinc, 1);
    tick(); chk("t4_b1", m_data, 8'hB1);
    tick(); chk("t4_b2", m_data, 8'hB2);
    tick(); chk("t4_b3", m_data, 8'hB3);
    m_ready = 1'b0;
    tick();
    chk("t4_two_data", m_data, 8'hB3);
    chk("t4_pcnt2", dut.pcnt, 2);
    flush = 1'b1; m_ready = 1'b1;
    #1 chk("t4_flush_rinc", fifo_rinc, 0);
    tick();
    chk("t4_flush_valid", m_valid, 0);
    chk("t4_flush_last", m_last, 0);
    chk("t4_flush_pcnt", dut.pcnt, 0);
    flush = 1'b0;
    #1 chk("t4_rinc_after", fifo_rinc, 1);
    for (int k = 5; k <= 8; k++) begin
      tick();
      chk("t4_data", m_data, 8'hB0 + 8'(k));
      chk("t4_last", m_last, (k == 8) ? 1 : 0);
    end
    tick();
    chk("t4_idle", m_valid, 0);

    // Reset while holding a word
    m_ready = 1'b0;
    load(8'hC1); load(8'hC2);
    #1 chk("t5_rinc0", fifo_rinc, 1);
    tick();
    chk("t5_valid", m_valid, 1);
    chk("t5_data", m_data, 8'hC1);
    rrst = 1'b1;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_last", m_last, 0);
    chk("t5_rst_rinc", fifo_rinc, 0);
    tick();
    chk("t5_post_valid", m_valid, 0);
    chk("t5_post_last", m_last, 0);
    chk("t5_post_data", m_data, 0);
    chk("t5_post_beat", beat_cnt, 0);
    rrst = 1'b0; m_ready = 1'b1;

    // Statistics: C2 plus nine more beats = 10 after reset
    for (int k = 1; k <= 9; k++) load(8'hD0 + 8'(k));
    repeat (14) tick();
    chk("t6_drained", m_valid, 0);
    chk("t6_fifo_empty", fifo_rempty, 1);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("t6_beats10", beat_cnt, 10);
    force dut.beat_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.beat_cnt;
    load(8'hE1); load(8'hE2); load(8'hE3);
    repeat (6) tick();
    chk("t6_sat", beat_cnt, 32'hFFFF_FFFF);
`else
    chk("t6_beats_off", beat_cnt, 0);
    load(8'hE1); load(8'hE2); load(8'hE3);
    repeat (6) tick();
    chk("t6_beats_off2", beat_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named rclk and rrst.
REQ-002 Parameter DSIZE SHALL default to 8 and set the data width.
REQ-003 Parameter PKT_LEN SHALL default to 4 and set the number of beats per packet, legal range 1..256.
REQ-004 Port rclk SHALL be an input, 1 bit wide: the read-domain clock.
REQ-005 Port rrst SHALL be an input, 1 bit wide: the synchronous active-high reset.
REQ-006 Port fifo_rempty SHALL be an input, 1 bit wide: the empty flag from the FIFO read side.
REQ-007 Port fifo_rdata SHALL be an input, DSIZE bits wide: the FIFO head word, combinational and valid whenever fifo_rempty is 0.
REQ-008 Port fifo_rinc SHALL be an output, 1 bit wide: the pop strobe to the FIFO.
REQ-009 Port flush SHALL be an input, 1 bit wide: discard all buffered words and restart packet framing.
REQ-010 Port m_valid SHALL be an output, 1 bit wide: the output stream valid.
REQ-011 Port m_ready SHALL be an input, 1 bit wide: the output stream ready.
REQ-012 Port m_data SHALL be an output, DSIZE bits wide: the output stream data.
REQ-013 Port m_last SHALL be an output, 1 bit wide: marks the final beat of a packet.
REQ-014 Port beat_cnt SHALL be an output, 32 bits wide: the accepted-beat statistic (see Configuration).

Function
REQ-015 The block SHALL hold a 2-entry skid buffer whose occupancy states are EMPTY, ONE and TWO.
REQ-016 A beat SHALL be accepted when m_valid and m_ready are both 1 in the same cycle.
REQ-017 fifo_rinc SHALL equal !fifo_rempty && !flush && (state != TWO || beat accepted this cycle).
REQ-018 fifo_rinc SHALL never assert while fifo_rempty is 1.
REQ-019 On a cycle with fifo_rinc = 1, the block SHALL capture fifo_rdata in that same cycle.
REQ-020 A captured word SHALL appear on m_data, with m_valid = 1, at the next rclk edge, giving 1-cycle latency when the buffer was EMPTY.
REQ-021 m_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-022 m_data SHALL always present the oldest buffered word.
REQ-023 m_data and m_last SHALL remain stable while m_valid = 1 and m_ready = 0.
REQ-024 State transitions SHALL be: push only -> occupancy + 1; accept only -> occupancy - 1; push and accept together -> occupancy unchanged and data shifts in order; neither -> hold.
REQ-025 When m_ready = 1 continuously and the FIFO never goes empty, throughput SHALL be 1 beat per cycle.
REQ-026 A packet counter pcnt, of width max(1, clog2(PKT_LEN)), SHALL increment on each accepted beat and wrap from PKT_LEN-1 to 0.
REQ-027 m_last SHALL equal m_valid && (pcnt == PKT_LEN-1).
REQ-028 When PKT_LEN = 1, m_last SHALL equal m_valid.
REQ-029 When flush = 1, the next state SHALL be EMPTY, pcnt SHALL become 0 and fifo_rinc SHALL be 0.
REQ-030 A beat accepted in the same cycle as flush SHALL count as delivered but SHALL NOT advance pcnt.
REQ-031 When rrst and flush are both 1, rrst SHALL take priority.

Reset
REQ-032 When rrst = 1 at an rclk edge, the state SHALL become EMPTY, pcnt 0 and beat_cnt 0.
REQ-033 While rrst = 1, m_valid, m_last and fifo_rinc SHALL be 0.
REQ-034 After reset, m_data SHALL be 0.
REQ-035 A reset asserted mid-packet SHALL discard the buffered words and restart framing at beat 0.

Configuration
REQ-036 With macro FIFO_RD_STREAM_STATS_EN defined, beat_cnt SHALL increment by 1 on every accepted beat and saturate at 32'hFFFF_FFFF.
REQ-037 With FIFO_RD_STREAM_STATS_EN defined, beat_cnt SHALL be unaffected by flush.
REQ-038 With FIFO_RD_STREAM_STATS_EN undefined, beat_cnt SHALL be tied to 0, no counter logic SHALL exist, and the port list SHALL be unchanged.

Structure
REQ-039 A shared package fifo_rd_stream_pkg SHALL hold the occupancy-state enum (EMPTY/ONE/TWO) and the constant STAT_W = 32.
REQ-040 The skid buffer SHALL be a single sub-module named rd_skid_buf; the framing and statistics logic SHALL stay in the top module.

Verification
REQ-041 FIFO preloaded with 0x11,0x22,0x33,0x44 and m_ready = 1 -> fifo_rinc high for 4 cycles; m_data = 11,22,33,44 on consecutive cycles starting 1 cycle after the first pop; m_last = 1 only with 0x44.
REQ-042 m_ready held 0 with the FIFO non-empty -> exactly 2 pops then fifo_rinc = 0, m_data held at the first word; raising m_ready -> words delivered in order with none lost.
REQ-043 fifo_rempty = 1 throughout -> fifo_rinc never asserts and m_valid stays 0.
REQ-044 flush asserted in state TWO mid-packet (pcnt = 2) -> next cycle m_valid = 0 and pcnt = 0; the next word delivered carries m_last only at its 4th beat.
REQ-045 rrst pulsed while m_valid = 1 -> next cycle m_valid = 0, m_last = 0, m_data = 0, beat_cnt = 0.
REQ-046 With FIFO_RD_STREAM_STATS_EN, 10 beats accepted -> beat_cnt = 10; with beat_cnt forced near 32'hFFFF_FFFE and 3 beats accepted -> beat_cnt = 32'hFFFF_FFFF; without the macro -> beat_cnt = 0 always.
